// File: rtl/ac2_acc_sequencer.sv
// Group accumulator feeding the AC2 counter: sums Pw words, strobes the counter per
// word, cross-checks the counter's terminal flag and hands the sum downstream.
module ac2_acc_sequencer #(
  parameter int Pw = 4,
  parameter int DW = 16,
  localparam int AW = DW + $clog2(Pw),
  localparam int IW = $clog2(Pw) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ac2_cnt,
  output logic          cnt_clear,
  input  logic          term_ac2,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_term
);

  // Handshakes: a word moves when in_valid & in_ready, the result moves when
  // out_valid & out_ready; both sides hold their payload stable until that cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic in_ready_c, ac2_cnt_c, cnt_clear_c, out_valid_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    err_d       = err_q;
    in_ready_c  = 1'b0;
    ac2_cnt_c   = 1'b0;
    cnt_clear_c = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear_c = 1'b1;
          acc_d       = '0;
          idx_d       = '0;
          err_d       = 1'b0;
          state_d     = ACC;
        end
      end
      ACC: begin
        // in_ready drops under abort so upstream never sees a phantom transfer.
        if (abort) begin
          cnt_clear_c = 1'b1;
          state_d     = IDLE;
        end else begin
          in_ready_c = 1'b1;
          if (in_valid) begin
            ac2_cnt_c = 1'b1;
            acc_d     = acc_q + AW'(in_data);
            idx_d     = idx_q + IW'(1);
            if (idx_q == IW'(Pw - 1)) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (abort) begin
          cnt_clear_c = 1'b1;
          state_d     = IDLE;
        end else begin
          if (!term_ac2) err_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          cnt_clear_c = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_c = 1'b1;
          if (out_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is held at 0 while reset is asserted, regardless of inputs.
  assign in_ready  = rst_n & in_ready_c;
  assign ac2_cnt   = rst_n & ac2_cnt_c;
  assign cnt_clear = rst_n & cnt_clear_c;
  assign out_valid = rst_n & out_valid_c;
  assign out_data  = rst_n ? acc_q : '0;
  assign busy      = rst_n & (state_q != IDLE);
  assign err_term  = rst_n & err_q;

endmodule

// File: tb/tb_ac2_acc_sequencer.sv
// Bench for ac2_acc_sequencer: directed groups from the test plan plus random
// groups, with a behavioural AC2 counter and a sum scoreboard.
module tb_ac2_acc_sequencer;
  localparam int PW = 4;
  localparam int DW = 8;
  localparam int AW = DW + $clog2(PW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, ac2_cnt, cnt_clear, term_ac2, out_valid, busy, err_term;
  logic [AW-1:0] out_data;

  ac2_acc_sequencer #(.Pw(PW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ac2_cnt(ac2_cnt), .cnt_clear(cnt_clear), .term_ac2(term_ac2),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err_term(err_term)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_q[$];
  logic          experr_q[$];

  // Behavioural AC2 counter: counts strobes since the last clear, terminal at PW.
  int   tcnt;
  logic force_term_zero = 1'b0;
  always @(posedge clk) begin
    if (!rst_n || cnt_clear) tcnt <= 0;
    else if (ac2_cnt) tcnt <= tcnt + 1;
  end
  assign term_ac2 = force_term_zero ? 1'b0 : (tcnt == PW);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each result transfer, checks strobe bookkeeping
  // and result stability while stalled.
  int            strobe_cnt = 0;
  logic          hold_v = 1'b0;
  logic [AW-1:0] hold_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_cnt = 0;
      hold_v     = 1'b0;
    end else begin
      check("strobe_eq_hs", ac2_cnt, in_valid & in_ready);
      if (cnt_clear) strobe_cnt = 0;
      if (ac2_cnt) strobe_cnt++;
      if (hold_v && out_valid) check("out_hold", out_data, hold_d);
      if (out_valid) check("valid_expected", exp_q.size() > 0, 1);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("out_data", out_data, exp_q.pop_front());
        check("err_term", err_term, experr_q.pop_front());
        check("strobes_per_group", strobe_cnt, PW);
      end
      hold_v = out_valid & ~out_ready;
      hold_d = out_data;
    end
  end

  logic [DW-1:0] grp_w[PW];
  int            g_gap, g_stall;
  bit            g_bad, g_glitch, g_rst;

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    check("clear_on_start", cnt_clear, 1);
    check("idle_before_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        check("strobe_on_word", ac2_cnt, 1);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("word_timeout", 0, 1);
  endtask

  task automatic run_group();
    int sum = 0;
    for (int i = 0; i < PW; i++) sum += int'(grp_w[i]);
    exp_q.push_back(AW'(sum));
    experr_q.push_back(g_bad);
    force_term_zero = g_bad;
    do_start();
    for (int i = 0; i < PW; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        if (g_glitch && i == 2) start = 1'b1;
        repeat (g_gap) begin @(posedge clk); #1; start = 1'b0; end
        if (g_gap == 0 && g_glitch && i == 2) begin @(posedge clk); #1; start = 1'b0; end
      end
      send_word(grp_w[i]);
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    @(negedge clk);
    check("check_no_valid", out_valid, 0);
    check("check_busy", busy, 1);
    check("err_clr", err_term, 0);
    @(posedge clk); #1;
    if (g_rst) begin
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_clear", cnt_clear, 0);
      void'(exp_q.pop_back());
      void'(experr_q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      start = 1'b0;
      force_term_zero = 1'b0;
      return;
    end
    out_ready = (g_stall == 0);
    start     = g_glitch;
    @(negedge clk);
    check("valid_2cyc", out_valid, 1);
    if (g_stall > 0) begin
      repeat (g_stall) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("idle_after_accept", busy, 0);
    check("valid_drop", out_valid, 0);
    force_term_zero = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int gap, input int stall, input bit bterm, input bit glitch, input bit rst);
    g_gap = gap; g_stall = stall; g_bad = bterm; g_glitch = glitch; g_rst = rst;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {in_ready, ac2_cnt, cnt_clear, out_valid, busy, err_term, out_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", {in_ready, ac2_cnt, cnt_clear, out_valid, busy, err_term, out_data}, 0);
    @(posedge clk); #1;

    grp_w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; set_cfg(0, 0, 0, 0, 0); run_group();
    grp_w = '{8'd1, 8'd2, 8'd3, 8'd4};     set_cfg(2, 5, 0, 0, 0); run_group();
    grp_w = '{8'd7, 8'd8, 8'd9, 8'd10};    set_cfg(0, 1, 1, 0, 0); run_group();

    // Abort after two words, with a third word offered in the abort cycle.
    do_start();
    send_word(8'd11);
    send_word(8'd12);
    in_data = 8'd13;
    abort   = 1'b1;
    @(negedge clk);
    check("abort_clear", cnt_clear, 1);
    check("abort_no_strobe", ac2_cnt, 0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_clear_once", cnt_clear, 0);
    @(posedge clk); #1;
    grp_w = '{8'd5, 8'd5, 8'd5, 8'd5}; set_cfg(0, 0, 0, 0, 0); run_group();

    grp_w = '{8'd9, 8'd9, 8'd9, 8'd9}; set_cfg(0, 0, 0, 0, 1); run_group();
    grp_w = '{8'd1, 8'd1, 8'd1, 8'd1}; set_cfg(0, 0, 0, 0, 0); run_group();

    grp_w = '{8'd20, 8'd30, 8'd40, 8'd50}; set_cfg(1, 2, 0, 1, 0); run_group();
    grp_w = '{8'd3, 8'd6, 8'd9, 8'd12};    set_cfg(0, 0, 0, 1, 0); run_group();

    for (int g = 0; g < 25; g++) begin
      for (int i = 0; i < PW; i++) grp_w[i] = DW'($urandom_range(0, 255));
      set_cfg($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, 0);
      run_group();
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
